ad5662_frame_writer: RTL and testbench

- Downstream stage of the VCTCXO discipline loop: it turns the loop's 16-bit DAC control word into AD5662 24-bit SPI write frames.
- It watches the requested code and power-down mode. When either differs from what was last written, or a write is forced, it sends one frame.
- It provides busy, frame-done and written-value status so the loop and its instrumentation can tell when a tuning step has reached the DAC.
- Runs entirely in the 200 MHz loop clock domain.

---
 rtl/ad5662_frame_writer.sv | 113 +++++++++++
 tb/tb_ad5662_frame_writer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ad5662_frame_writer.sv
// AD5662 SPI frame writer: sends a 24-bit {6'b0, pd, dat} frame whenever the
// requested code/power-down differs from the last one written, or on a force.
module ad5662_frame_writer #(
  parameter int HALF = 4,
  parameter int GAP  = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] dat,
  input  logic [1:0]  pd,
  input  logic        force_wr,
  output logic        sclk,
  output logic        mosi,
  output logic        sync_n,
  output logic        busy,
  output logic        done,
  output logic [15:0] wr_val
);

  localparam int HW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int GW = $clog2(GAP + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_TAIL, S_GAP} state_t;

  state_t        state, state_nx;
  logic [HW-1:0] hcnt;
  logic          phase;
  logic [4:0]    bcnt;
  logic [GW-1:0] gcnt;
  logic [23:0]   shreg;
  logic [15:0]   last_dat;
  logic [1:0]    last_pd;
  logic          pending;
  logic          trigger, half_end, bit_end, last_bit, gap_end;

  assign trigger  = pending | force_wr | (dat != last_dat) | (pd != last_pd);
  assign half_end = (hcnt == HW'(HALF - 1));
  assign bit_end  = half_end & phase;
  assign last_bit = bit_end & (bcnt == 5'd0);
  assign gap_end  = (gcnt == GW'(GAP));

  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (trigger)  state_nx = S_SHIFT;
      S_SHIFT: if (last_bit) state_nx = S_TAIL;
      S_TAIL:  if (half_end) state_nx = S_GAP;
      S_GAP:   if (gap_end)  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hcnt     <= '0;
      phase    <= 1'b0;
      bcnt     <= 5'd23;
      gcnt     <= '0;
      shreg    <= '0;
      last_dat <= '0;
      last_pd  <= '0;
      pending  <= 1'b1;
      wr_val   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          hcnt  <= '0;
          phase <= 1'b0;
          bcnt  <= 5'd23;
          gcnt  <= '0;
          if (trigger) begin
            shreg    <= {6'b000000, pd, dat};
            last_dat <= dat;
            last_pd  <= pd;
            pending  <= 1'b0;
          end
        end
        S_SHIFT: begin
          hcnt <= half_end ? '0 : hcnt + HW'(1);
          if (half_end) phase <= ~phase;
          // Shift only at the end of a low phase so mosi moves with sclk rising.
          if (bit_end) begin
            shreg <= {shreg[22:0], 1'b0};
            if (bcnt != 5'd0) bcnt <= bcnt - 5'd1;
          end
        end
        S_TAIL: begin
          hcnt  <= half_end ? '0 : hcnt + HW'(1);
          phase <= 1'b0;
          if (half_end) wr_val <= last_dat;
        end
        S_GAP: gcnt <= gcnt + GW'(1);
        default: ;
      endcase
      // A force seen while busy is remembered and served at the next IDLE.
      if (force_wr && state != S_IDLE) pending <= 1'b1;
    end
  end

  always_comb begin
    sclk   = !(state == S_SHIFT && phase);
    sync_n = !(state == S_SHIFT || state == S_TAIL);
    mosi   = (state == S_SHIFT) ? shreg[23] : 1'b0;
    busy   = (state != S_IDLE);
    done   = (state == S_GAP) && (gcnt == '0);
  end

endmodule

// File: tb/tb_ad5662_frame_writer.sv
// Directed bench for ad5662_frame_writer: a negedge monitor reconstructs frames
// from the SPI pins and the main sequence compares them with expected words.
module tb_ad5662_frame_writer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] dat;
  logic [1:0]  pd;
  logic        force_wr;
  logic        sclk, mosi, sync_n, busy, done;
  logic [15:0] wr_val;

  int n_assert = 0;
  int n_fail   = 0;

  ad5662_frame_writer #(.HALF(4), .GAP(8)) dut (
    .clk(clk), .reset_n(reset_n), .dat(dat), .pd(pd), .force_wr(force_wr),
    .sclk(sclk), .mosi(mosi), .sync_n(sync_n), .busy(busy), .done(done),
    .wr_val(wr_val)
  );

  always #2.5 clk = ~clk;

  // monitor state
  int          cyc = 0;
  int          nframes = 0;
  int          falls = 0;
  int          low_len = 0;
  int          viol = 0;
  int          last_fall = 0, last_rise = 0, last_gap = 0, last_per = 0;
  logic [23:0] cap = '0;
  logic        prev_sclk = 1'b1, prev_mosi = 1'b0, prev_sync = 1'b1;
  logic [23:0] frame_q[$];
  logic [23:0] exp_q[$];
  int          falls_q[$], low_q[$], lat_q[$];
  logic [15:0] wr_q[$];

  always @(negedge clk) begin
    cyc++;
    if (prev_sync && !sync_n) begin
      last_per  = cyc - last_fall;
      last_gap  = cyc - last_rise;
      last_fall = cyc;
      cap = '0; falls = 0; low_len = 0;
    end
    if (!prev_sync && sync_n) last_rise = cyc;
    if (!sync_n) begin
      low_len++;
      if (prev_sclk && !sclk) begin
        cap = {cap[22:0], mosi};
        falls++;
      end
      if (!prev_sync && (mosi !== prev_mosi) && !(!prev_sclk && sclk)) viol++;
    end
    if (done) begin
      frame_q.push_back(cap);
      falls_q.push_back(falls);
      low_q.push_back(low_len);
      lat_q.push_back(cyc - last_fall + 1);
      wr_q.push_back(wr_val);
      nframes++;
    end
    prev_sclk = sclk; prev_mosi = mosi; prev_sync = sync_n;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy && k < 1000) begin @(negedge clk); k++; end
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  // Waits for as many frames as are expected, then checks each one.
  task automatic check_frames(input string tag);
    int n = exp_q.size();
    int k = 0;
    logic [23:0] f, e;
    logic [15:0] w;
    while (frame_q.size() < n && k < 3000) begin @(negedge clk); k++; end
    chk({tag, "_count"}, 32'(frame_q.size()), 32'(n));
    while (exp_q.size() > 0 && frame_q.size() > 0) begin
      e = exp_q.pop_front();
      f = frame_q.pop_front();
      w = wr_q.pop_front();
      chk({tag, "_word"},  {8'h0, f}, {8'h0, e});
      chk({tag, "_falls"}, 32'(falls_q.pop_front()), 32'd24);
      chk({tag, "_low"},   32'(low_q.pop_front()), 32'd196);
      chk({tag, "_lat"},   32'(lat_q.pop_front()), 32'd197);
      chk({tag, "_wrval"}, {16'h0, w}, {16'h0, e[15:0]});
    end
    exp_q.delete();
    frame_q.delete(); falls_q.delete(); low_q.delete(); lat_q.delete(); wr_q.delete();
  endtask

  initial begin
    int base;
    int k;
    reset_n = 1'b0; dat = 16'h7FFF; pd = 2'b00; force_wr = 1'b0;
    cycles(3);
    chk("rst_sclk",   32'(sclk),   32'd1);
    chk("rst_sync",   32'(sync_n), 32'd1);
    chk("rst_mosi",   32'(mosi),   32'd0);
    chk("rst_busy",   32'(busy),   32'd0);
    chk("rst_done",   32'(done),   32'd0);
    chk("rst_wrval",  32'(wr_val), 32'd0);
    reset_n = 1'b1;

    // one frame after reset, then silence
    exp_q.push_back(24'h007FFF);
    check_frames("post_reset");
    cycles(300);
    chk("post_reset_quiet", 32'(nframes), 32'd1);

    // dat step in IDLE
    wait_idle("step");
    dat = 16'h1234;
    exp_q.push_back(24'h001234);
    check_frames("step");
    chk("step_mosi_viol", 32'(viol), 32'd0);

    // pd change alone
    wait_idle("pd");
    pd = 2'b01;
    exp_q.push_back(24'h011234);
    check_frames("pd");

    // mid-frame changes: only AAAA and the final 0F0F are written
    wait_idle("mid");
    base = nframes;
    pd = 2'b00; dat = 16'hAAAA;
    k = 0;
    while (sync_n && k < 100) begin @(negedge clk); k++; end
    chk("mid_start", 32'(sync_n), 32'd0);
    cycles(20);
    dat = 16'h5555;
    cycles(50);
    dat = 16'h0F0F;
    exp_q.push_back(24'h00AAAA);
    exp_q.push_back(24'h000F0F);
    check_frames("mid");
    chk("mid_gap_min", 32'(last_gap >= 9), 32'd1);
    chk("mid_period",  32'(last_per), 32'd206);
    cycles(300);
    chk("mid_total", 32'(nframes - base), 32'd2);

    // force in IDLE with no change
    wait_idle("force_idle");
    base = nframes;
    force_wr = 1'b1; @(negedge clk); force_wr = 1'b0;
    exp_q.push_back(24'h000F0F);
    check_frames("force_idle");
    cycles(300);
    chk("force_idle_total", 32'(nframes - base), 32'd1);

    // force while busy adds exactly one more identical frame
    wait_idle("force_busy");
    base = nframes;
    force_wr = 1'b1; @(negedge clk); force_wr = 1'b0;
    cycles(40);
    force_wr = 1'b1; @(negedge clk); force_wr = 1'b0;
    exp_q.push_back(24'h000F0F);
    exp_q.push_back(24'h000F0F);
    check_frames("force_busy");
    cycles(300);
    chk("force_busy_total", 32'(nframes - base), 32'd2);

    // reset at the 10th falling sclk edge
    wait_idle("abort");
    dat = 16'h3C3C;
    k = 0;
    while (!(falls == 10 && !sync_n) && k < 500) begin @(negedge clk); k++; end
    chk("abort_reach10", 32'(falls), 32'd10);
    base = nframes;
    reset_n = 1'b0;
    @(negedge clk);
    chk("abort_sync",  32'(sync_n), 32'd1);
    chk("abort_sclk",  32'(sclk),   32'd1);
    chk("abort_busy",  32'(busy),   32'd0);
    chk("abort_wrval", 32'(wr_val), 32'd0);
    cycles(2);
    reset_n = 1'b1;
    exp_q.push_back(24'h003C3C);
    check_frames("abort");
    chk("abort_total", 32'(nframes - base), 32'd1);
    chk("final_mosi_viol", 32'(viol), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
